// File: rtl/info_printer_pkg.sv
// Shared types and constants for the info_printer string/value print engine.
package info_printer_pkg;

   typedef enum logic [2:0] {
      IDLE,
      FETCH,
      WAIT_STR,
      HEX,
      WAIT_HEX,
      LF,
      WAIT_LF,
      DONE
   } state_t;

   localparam logic [7:0] ASCII_NUL      = 8'h00;
   localparam logic [7:0] ASCII_LF       = 8'h0A;
   localparam logic [7:0] ASCII_ZERO     = 8'h30;
   // 'A' minus ten, so digit values 10..15 land on 'A'..'F'
   localparam logic [7:0] ASCII_HEX_BASE = 8'h37;
   localparam int         NIBBLE_COUNT   = 8;

endpackage

// File: rtl/info_printer_nib2ascii.sv
// nib2ascii: combinational 4-bit value to upper-case ASCII hex digit.
module nib2ascii
   import info_printer_pkg::*;
(
   input  logic [3:0] nib,
   output logic [7:0] ascii
);

   always_comb begin
      // NOTE: assign a default before any conditional update so no path leaves ascii unassigned (avoids a latch).
      ascii = ASCII_ZERO + {4'h0, nib};
      if (nib > 4'd9) begin
         ascii = ASCII_HEX_BASE + {4'h0, nib};
      end
   end

endmodule

// File: rtl/info_printer.sv
// info_printer: streams a NUL-terminated ROM string to a UART, optionally the value as 8 hex digits, then LF.
// Build option: define INFO_HEX_APPEND_EN to append the hex digits of value.
module info_printer
   import info_printer_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 10,
   parameter int MAX_LEN    = 64
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [ADDR_WIDTH-1:0] base_addr,
   input  logic [31:0]           value,
   output logic [ADDR_WIDTH-1:0] rom_addr,
   input  logic [DATA_WIDTH-1:0] rom_dout,
   output logic [7:0]            tx_data,
   output logic                  tx_valid,
   input  logic                  tx_ready,
   output logic                  busy,
   output logic                  done
);

   localparam int CNT_W = $clog2(MAX_LEN + 1);

   state_t                state;
   logic [ADDR_WIDTH-1:0] ptr;
   logic [CNT_W-1:0]      count;
   logic [7:0]            rom_char;
   logic                  str_end;
   logic                  unused_rom;

   assign rom_addr   = ptr;
   assign rom_char   = rom_dout[7:0];
   assign unused_rom = ^rom_dout;
   assign str_end    = (rom_char == ASCII_NUL) || (count == CNT_W'(MAX_LEN));

`ifdef INFO_HEX_APPEND_EN
   logic [31:0] val_q;
   logic [2:0]  nib_idx;
   logic [7:0]  hex_char;

   // val_q shifts left after each digit, so the next digit is always the top nibble
   nib2ascii u_nib2ascii (
      .nib   (val_q[31:28]),
      .ascii (hex_char)
   );

   localparam state_t STR_NEXT = HEX;
`else
   logic unused_value;

   assign unused_value = ^value;

   localparam state_t STR_NEXT = LF;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         ptr      <= '0;
         count    <= '0;
         tx_data  <= ASCII_NUL;
         tx_valid <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
`ifdef INFO_HEX_APPEND_EN
         val_q    <= '0;
         nib_idx  <= '0;
`endif
      end else begin
         // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  ptr   <= base_addr;
                  count <= '0;
                  busy  <= 1'b1;
                  state <= FETCH;
`ifdef INFO_HEX_APPEND_EN
                  val_q   <= value;
                  nib_idx <= '0;
`endif
               end
            end
            FETCH: begin
               if (str_end) begin
                  state <= STR_NEXT;
               end else begin
                  tx_data  <= rom_char;
                  tx_valid <= 1'b1;
                  state    <= WAIT_STR;
               end
            end
            WAIT_STR: begin
               if (tx_ready) begin
                  tx_valid <= 1'b0;
                  ptr      <= ptr + 1'b1;
                  count    <= count + 1'b1;
                  state    <= FETCH;
               end
            end
`ifdef INFO_HEX_APPEND_EN
            HEX: begin
               tx_data  <= hex_char;
               tx_valid <= 1'b1;
               state    <= WAIT_HEX;
            end
            WAIT_HEX: begin
               if (tx_ready) begin
                  tx_valid <= 1'b0;
                  val_q    <= {val_q[27:0], 4'h0};
                  if (nib_idx == 3'(NIBBLE_COUNT - 1)) begin
                     state <= LF;
                  end else begin
                     nib_idx <= nib_idx + 1'b1;
                     state   <= HEX;
                  end
               end
            end
`endif
            LF: begin
               tx_data  <= ASCII_LF;
               tx_valid <= 1'b1;
               state    <= WAIT_LF;
            end
            WAIT_LF: begin
               if (tx_ready) begin
                  tx_valid <= 1'b0;
                  done     <= 1'b1;
                  state    <= DONE;
               end
            end
            DONE: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: begin
               tx_valid <= 1'b0;
               busy     <= 1'b0;
               state    <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_info_printer.sv
// Self-checking bench for info_printer: directed scenarios plus randomized strings against a byte-stream model.
module tb_info_printer;

   typedef logic [7:0] byte_q_t[$];

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start = 1'b0;
   logic [9:0] base_addr = '0;
   logic [31:0] value = '0;
   logic [9:0] rom_addr;
   logic [7:0] rom_dout;
   logic [7:0] tx_data;
   logic       tx_valid;
   logic       tx_ready = 1'b1;
   logic       busy;
   logic       done;

   logic       start4 = 1'b0;
   logic [9:0] base_addr4 = '0;
   logic [31:0] value4 = '0;
   logic [9:0] rom_addr4;
   logic [7:0] rom_dout4;
   logic [7:0] tx_data4;
   logic       tx_valid4;
   logic       busy4;
   logic       done4;

   logic [7:0] rom [0:1023];

   int pass_cnt = 0;
   int total_cnt = 0;

   // monitor-owned
   byte_q_t    got;
   byte_q_t    got4;
   int         done_cnt = 0;
   int         done4_cnt = 0;
   int         stab_err = 0;
   logic       pending = 1'b0;
   logic [7:0] pend_data = '0;

   // ready driver control (written by tests) and state (ready driver only)
   int         hold_n = 0;
   int         hold_epoch = 0;
   bit         random_ready = 1'b0;
   int         seen_epoch = 0;
   int         low_seen = 0;

   // per-request bookkeeping
   int         got_base = 0;
   int         done_base = 0;
   int         stab_base = 0;

   always #5 clk = ~clk;

   assign rom_dout  = rom[rom_addr];
   assign rom_dout4 = rom[rom_addr4];

   info_printer dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .base_addr (base_addr),
      .value     (value),
      .rom_addr  (rom_addr),
      .rom_dout  (rom_dout),
      .tx_data   (tx_data),
      .tx_valid  (tx_valid),
      .tx_ready  (tx_ready),
      .busy      (busy),
      .done      (done)
   );

   info_printer #(.MAX_LEN(4)) dut4 (
      .clk       (clk),
      .rst       (rst),
      .start     (start4),
      .base_addr (base_addr4),
      .value     (value4),
      .rom_addr  (rom_addr4),
      .rom_dout  (rom_dout4),
      .tx_data   (tx_data4),
      .tx_valid  (tx_valid4),
      .tx_ready  (tx_ready),
      .busy      (busy4),
      .done      (done4)
   );

   always @(negedge clk) begin
      if (hold_epoch != seen_epoch) begin
         seen_epoch = hold_epoch;
         low_seen   = 0;
      end
      if (low_seen < hold_n && tx_valid) begin
         tx_ready = 1'b0;
         low_seen = low_seen + 1;
      end else if (random_ready) begin
         tx_ready = ($urandom_range(0, 2) != 0);
      end else begin
         tx_ready = 1'b1;
      end
   end

   // a handshake is recorded when valid&&ready are both high just before the rising edge
   always @(negedge clk) begin
      #1;
      if (rst) begin
         pending = 1'b0;
      end else begin
         if (pending && (!tx_valid || tx_data !== pend_data)) stab_err = stab_err + 1;
         if (done) done_cnt = done_cnt + 1;
         if (tx_valid && tx_ready) got.push_back(tx_data);
         pending   = tx_valid && !tx_ready;
         pend_data = tx_data;
         if (done4) done4_cnt = done4_cnt + 1;
         if (tx_valid4 && tx_ready) got4.push_back(tx_data4);
      end
   end

   task automatic model(input logic [9:0] b, input logic [31:0] v, input int maxlen,
                        output byte_q_t q);
      logic [7:0] c;
      int         nib;
      q = {};
      for (int i = 0; i < maxlen; i++) begin
         c = rom[(int'(b) + i) % 1024];
         if (c == 8'h00) break;
         q.push_back(c);
      end
`ifdef INFO_HEX_APPEND_EN
      for (int n = 7; n >= 0; n--) begin
         nib = int'((v >> (4 * n)) & 32'hF);
         q.push_back(nib < 10 ? 8'(8'h30 + nib) : 8'(8'h41 + nib - 10));
      end
`else
      nib = int'(v[0]);
`endif
      q.push_back(8'h0A);
   endtask

   task automatic set_hold(input int n);
      hold_n     = n;
      hold_epoch = hold_epoch + 1;
   endtask

   task automatic start_request(input logic [9:0] b, input logic [31:0] v, input string name);
      got_base  = got.size();
      done_base = done_cnt;
      stab_base = stab_err;
      @(negedge clk);
      base_addr = b;
      value     = v;
      start     = 1'b1;
      @(negedge clk);
      start = 1'b0;
      #2;
      total_cnt++;
      if (busy !== 1'b1) $display("FAIL %s busy_after_start: got %b want 1", name, busy);
      else pass_cnt++;
   endtask

   task automatic finish_request(input byte_q_t e, input string name);
      int n;
      int gn;
      int diff;
      logic [7:0] gb;
      logic [7:0] eb;
      n = 0;
      while (done_cnt == done_base && n < 3000) begin
         @(negedge clk);
         #2;
         n++;
      end
      total_cnt++;
      if (done_cnt == done_base) $display("FAIL %s done_timeout: no done after %0d cycles, want done", name, n);
      else pass_cnt++;
      repeat (3) @(negedge clk);
      #2;
      total_cnt++;
      if (done_cnt - done_base !== 1) $display("FAIL %s done_pulses: got %0d want 1", name, done_cnt - done_base);
      else pass_cnt++;
      total_cnt++;
      if (busy !== 1'b0) $display("FAIL %s busy_after_done: got %b want 0", name, busy);
      else pass_cnt++;
      gn   = got.size() - got_base;
      diff = -1;
      for (int i = 0; i < e.size() && i < gn; i++) begin
         if (diff < 0 && got[got_base + i] !== e[i]) diff = i;
      end
      if (diff < 0 && gn != e.size()) diff = (gn < e.size()) ? gn : e.size();
      gb = (diff >= 0 && diff < gn) ? got[got_base + diff] : 8'h00;
      eb = (diff >= 0 && diff < e.size()) ? e[diff] : 8'h00;
      total_cnt++;
      if (diff >= 0)
         $display("FAIL %s stream: got %0d bytes want %0d, first diff at %0d (got %h want %h)",
                  name, gn, e.size(), diff, gb, eb);
      else pass_cnt++;
      total_cnt++;
      if (stab_err != stab_base) $display("FAIL %s handshake_stability: got %0d violations want 0", name, stab_err - stab_base);
      else pass_cnt++;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(negedge clk);
      #2;
      total_cnt++;
      if ({tx_valid, busy, done} !== 3'b000) $display("FAIL reset_ctrl: got valid/busy/done=%b want 000", {tx_valid, busy, done});
      else pass_cnt++;
      total_cnt++;
      if (tx_data !== 8'h00) $display("FAIL reset_tx_data: got %h want 00", tx_data);
      else pass_cnt++;
      total_cnt++;
      if (rom_addr !== 10'h000) $display("FAIL reset_rom_addr: got %h want 000", rom_addr);
      else pass_cnt++;
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_basic();
      byte_q_t e;
      rom[10'h010] = 8'h50;
      rom[10'h011] = 8'h43;
      rom[10'h012] = 8'h00;
`ifdef INFO_HEX_APPEND_EN
      e = '{8'h50, 8'h43, 8'h30, 8'h30, 8'h30, 8'h30, 8'h41, 8'h42, 8'h43, 8'h44, 8'h0A};
`else
      e = '{8'h50, 8'h43, 8'h0A};
`endif
      start_request(10'h010, 32'h0000ABCD, "basic");
      total_cnt++;
      if (rom_addr !== 10'h010) $display("FAIL basic_rom_addr: got %h want 010", rom_addr);
      else pass_cnt++;
      finish_request(e, "basic");
   endtask

   task automatic test_backpressure();
      byte_q_t e;
      int      n;
      rom[10'h010] = 8'h50;
      rom[10'h011] = 8'h43;
      rom[10'h012] = 8'h00;
      model(10'h010, 32'h0000ABCD, 64, e);
      set_hold(5);
      start_request(10'h010, 32'h0000ABCD, "stall");
      n = 0;
      while (!tx_valid && n < 20) begin
         @(negedge clk);
         #2;
         n++;
      end
      for (int k = 0; k < 5; k++) begin
         total_cnt++;
         if (tx_valid !== 1'b1 || tx_data !== 8'h50 || tx_ready !== 1'b0)
            $display("FAIL stall_hold_%0d: got valid=%b data=%h ready=%b want valid=1 data=50 ready=0",
                     k, tx_valid, tx_data, tx_ready);
         else pass_cnt++;
         @(negedge clk);
         #2;
      end
      finish_request(e, "stall");
      set_hold(0);
   endtask

   task automatic test_wrap();
      byte_q_t e;
      rom[10'h3FE] = 8'h41;
      rom[10'h3FF] = 8'h42;
      rom[10'h000] = 8'h43;
      rom[10'h001] = 8'h00;
`ifdef INFO_HEX_APPEND_EN
      e = '{8'h41, 8'h42, 8'h43, 8'h30, 8'h30, 8'h30, 8'h30, 8'h30, 8'h30, 8'h30, 8'h30, 8'h0A};
`else
      e = '{8'h41, 8'h42, 8'h43, 8'h0A};
`endif
      start_request(10'h3FE, 32'h0, "wrap");
      finish_request(e, "wrap");
   endtask

   task automatic test_maxlen();
      byte_q_t e;
      int      n;
      int      base4;
      for (int i = 0; i < 6; i++) rom[10'h200 + i] = 8'(8'h61 + i);
      rom[10'h206] = 8'h00;
      model(10'h200, 32'hDEADBEEF, 4, e);
      base4 = got4.size();
      @(negedge clk);
      base_addr4 = 10'h200;
      value4     = 32'hDEADBEEF;
      start4     = 1'b1;
      @(negedge clk);
      start4 = 1'b0;
      n = 0;
      while (done4_cnt == 0 && n < 500) begin
         @(negedge clk);
         #2;
         n++;
      end
      repeat (2) @(negedge clk);
      #2;
      total_cnt++;
      if (done4_cnt !== 1) $display("FAIL maxlen_done: got %0d pulses want 1", done4_cnt);
      else pass_cnt++;
      total_cnt++;
      if (got4.size() - base4 !== e.size() || got4[base4 + 3] !== 8'h64 || got4[base4 + 4] === 8'h65)
         $display("FAIL maxlen_stream: got %0d bytes want %0d (4 string bytes 61..64)", got4.size() - base4, e.size());
      else pass_cnt++;
      total_cnt++;
      if (got4[got4.size() - 1] !== 8'h0A || busy4 !== 1'b0)
         $display("FAIL maxlen_tail: got last=%h busy=%b want last=0a busy=0", got4[got4.size() - 1], busy4);
      else pass_cnt++;
   endtask

   task automatic test_empty();
      byte_q_t e;
      rom[10'h100] = 8'h00;
`ifdef INFO_HEX_APPEND_EN
      e = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h0A};
`else
      e = '{8'h0A};
`endif
      start_request(10'h100, 32'h12345678, "empty");
      finish_request(e, "empty");
   endtask

   task automatic test_busy_start_ignored();
      byte_q_t e;
      int      n;
      for (int i = 0; i < 5; i++) rom[10'h080 + i] = 8'(8'h70 + i);
      rom[10'h085] = 8'h00;
      rom[10'h090] = 8'h5A;
      rom[10'h091] = 8'h00;
      model(10'h080, 32'hCAFE0123, 64, e);
      random_ready = 1'b1;
      start_request(10'h080, 32'hCAFE0123, "ignore");
      repeat (4) @(negedge clk);
      base_addr = 10'h090;
      value     = 32'h55555555;
      start     = 1'b1;
      @(negedge clk);
      start = 1'b0;
      finish_request(e, "ignore");
      random_ready = 1'b0;
      n = got.size();
      repeat (10) @(negedge clk);
      #2;
      total_cnt++;
      if (got.size() !== n || busy !== 1'b0) $display("FAIL ignore_no_rerun: got %0d extra bytes busy=%b want 0 extra busy=0", got.size() - n, busy);
      else pass_cnt++;
   endtask

   task automatic test_reset_midway();
      int n;
      int g0;
      int d0;
      rom[10'h010] = 8'h50;
      rom[10'h011] = 8'h43;
      rom[10'h012] = 8'h00;
      set_hold(1000);
      start_request(10'h010, 32'h0000ABCD, "midrst");
      n = 0;
      while (!tx_valid && n < 20) begin
         @(negedge clk);
         #2;
         n++;
      end
      #1;
      rst = 1'b1;
      #1;
      total_cnt++;
      if (tx_valid !== 1'b0 || busy !== 1'b0 || rom_addr !== 10'h000)
         $display("FAIL midrst_async: got valid=%b busy=%b rom_addr=%h want 0 0 000", tx_valid, busy, rom_addr);
      else pass_cnt++;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      set_hold(0);
      g0 = got.size();
      d0 = done_cnt;
      repeat (10) @(negedge clk);
      #2;
      total_cnt++;
      if (done_cnt !== d0 || got.size() !== g0 || busy !== 1'b0)
         $display("FAIL midrst_abandon: got done=%0d bytes=%0d busy=%b want 0 0 0", done_cnt - d0, got.size() - g0, busy);
      else pass_cnt++;
   endtask

   task automatic test_random();
      byte_q_t     e;
      logic [9:0]  b;
      logic [31:0] v;
      int          len;
      random_ready = 1'b1;
      for (int it = 0; it < 20; it++) begin
         b   = 10'($urandom_range(0, 1023));
         v   = $urandom;
         len = $urandom_range(0, 70);
         for (int i = 0; i < len; i++) rom[(int'(b) + i) % 1024] = 8'($urandom_range(1, 255));
         rom[(int'(b) + len) % 1024] = 8'h00;
         model(b, v, 64, e);
         start_request(b, v, $sformatf("rand%0d", it));
         finish_request(e, $sformatf("rand%0d", it));
      end
      random_ready = 1'b0;
   endtask

   initial begin
      for (int i = 0; i < 1024; i++) rom[i] = 8'h00;
      test_reset();
      test_basic();
      test_backpressure();
      test_wrap();
      test_maxlen();
      test_empty();
      test_busy_start_ignored();
      test_reset_midway();
      test_basic();
      test_random();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule

// File: doc/info_printer.md
INFO_PRINTER -- requirements
Module: info_printer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, ROM word width; characters are its low 8 bits.
REQ-002 SHALL have parameter ADDR_WIDTH, default 10, info-ROM address width.
REQ-003 SHALL have parameter MAX_LEN, default 64, maximum string characters emitted per request.
REQ-004 SHALL have port clk  in  1  single clock, rising edge.
REQ-005 SHALL have port rst  in  1  reset, asynchronous, active-high.
REQ-006 SHALL have port start  in  1  request pulse, sampled in IDLE only.
REQ-007 SHALL have port base_addr  in  ADDR_WIDTH  first ROM address of the string.
REQ-008 SHALL have port value  in  32  value printed after the string.
REQ-009 SHALL have port rom_addr  out  ADDR_WIDTH  address to info ROM.
REQ-010 SHALL have port rom_dout  in  DATA_WIDTH  ROM data, combinational from rom_addr.
REQ-011 SHALL have port tx_data  out  8  character to UART transmitter.
REQ-012 SHALL have port tx_valid  out  1  tx_data valid.
REQ-013 SHALL have port tx_ready  in  1  transmitter accepts character.
REQ-014 SHALL have ports busy  out  1 (request in progress) and done  out  1 (one-cycle completion pulse).

Function
REQ-015 SHALL implement FSM states IDLE, FETCH, WAIT_STR, HEX, WAIT_HEX, LF, WAIT_LF, DONE.
REQ-016 IDLE: on start, SHALL latch base_addr into ptr and value into val_q, clear count, enter FETCH next cycle.
REQ-017 FETCH: SHALL drive rom_addr=ptr; if rom_dout[7:0]==0x00 or count==MAX_LEN, SHALL go to HEX (macro on) or LF (macro off); else SHALL register tx_data=rom_dout[7:0], set tx_valid, enter WAIT_STR.
REQ-018 WAIT_STR: on tx_valid&&tx_ready SHALL clear tx_valid, increment ptr modulo 2^ADDR_WIDTH (0x3FF wraps to 0x000), increment count, return to FETCH.
REQ-019 HEX/WAIT_HEX: SHALL emit the 8 nibbles of val_q, MSB first, as ASCII '0'-'9' (0x30-0x39), 'A'-'F' (0x41-0x46), one handshake each.
REQ-020 LF/WAIT_LF: SHALL emit 0x0A with one handshake, then enter DONE.
REQ-021 DONE: SHALL assert done for exactly one cycle, return to IDLE.
REQ-022 Handshake: once tx_valid is high, tx_valid and tx_data SHALL stay constant until the cycle tx_ready is sampled high; tx_valid SHALL never depend combinationally on tx_ready.
REQ-023 busy SHALL be high in every state except IDLE; start while busy SHALL be ignored.
REQ-024 A string whose first character is 0x00 SHALL emit no string characters.
REQ-025 rom_addr SHALL equal ptr in all states.

Reset
REQ-026 On rst high SHALL asynchronously force state=IDLE, tx_valid=0, tx_data=0x00, busy=0, done=0, ptr=0, count=0, val_q=0, abandoning any request in progress.
REQ-027 After rst deasserts, the first start SHALL be accepted normally.

Configuration
REQ-028 Macro INFO_HEX_APPEND_EN defined: HEX/WAIT_HEX states SHALL be compiled in per REQ-019.
REQ-029 Macro undefined: HEX states SHALL be omitted, FETCH termination SHALL go to LF, value SHALL be ignored (port retained).

Structure
REQ-030 Shared package SHALL hold the state enum typedef, ASCII constants (NUL 0x00, LF 0x0A) and the nibble count 8.
REQ-031 Nibble-to-ASCII conversion SHALL be a sub-module nib2ascii (4-bit in, 8-bit out, combinational).

Verification
REQ-032 ROM[0x010..0x012]="P","C",0x00, value=0x0000ABCD, tx_ready=1, macro on -> tx bytes 50 43 30 30 30 30 41 42 43 44 0A, then done one cycle, busy low.
REQ-033 Same stimulus, macro off -> tx bytes 50 43 0A only.
REQ-034 tx_ready held 0 for 5 cycles at first character -> tx_valid=1, tx_data=0x50 stable all 5 cycles; no byte lost or duplicated.
REQ-035 base_addr=0x3FE, ROM[0x3FE]=0x41, [0x3FF]=0x42, [0x000]=0x43, [0x001]=0x00 -> string bytes 41 42 43; MAX_LEN=4 with no NUL -> exactly 4 string bytes.
REQ-036 rst pulsed during WAIT_STR -> tx_valid=0 and busy=0 in same cycle, no done; start during busy -> ignored.
REQ-037 ROM[base]=0x00, value=0x12345678 -> 31 32 33 34 35 36 37 38 0A.
